// File: rtl/alarm_ringer.sv
// ---------------------------------------------------------------------------
// alarm_ringer
//
// Alarm ringing controller that sits directly downstream of the clock/alarm
// datapath. It compares the running hh:mm BCD digits against the alarm
// setting and runs a ring / snooze / dismiss state machine. While ringing, it
// drives the 8-LED alarm bar with a rotating single-bit chase.
//
// Parameters
//   RING_SECONDS   seconds of ringing before auto-stop (1..255)
//   SNOOZE_MINUTES snooze delay in minutes (1..59)
//   MAX_SNOOZE     snoozes allowed per alarm event (0..7)
//
// Ports
//   clk                      system clock (only clock)
//   reset                    synchronous, active-high
//   sec_tick                 1 Hz one-cycle enable
//   anim_tick                one-cycle enable, LED chase step
//   hr_1/hr_0/min_1/min_0    current time, BCD 00:00..23:59
//   al_hr_1/.../al_min_0     alarm time, BCD
//   alarm_en                 alarm switch (level)
//   suppress                 blocks new triggers (stopwatch / set mode)
//   snooze_op, dismiss_op    one-pulse button strobes
//   led_alarm                LED bar, chase pattern while ringing
//   ringing                  high while in RING
//   snoozed                  high while in SNOOZE
//   snooze_time              snooze target {h1,h0,m1,m0} BCD
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module alarm_ringer #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sec_tick,
    input  logic        anim_tick,
    input  logic [3:0]  hr_1,
    input  logic [3:0]  hr_0,
    input  logic [3:0]  min_1,
    input  logic [3:0]  min_0,
    input  logic [3:0]  al_hr_1,
    input  logic [3:0]  al_hr_0,
    input  logic [3:0]  al_min_1,
    input  logic [3:0]  al_min_0,
    input  logic        alarm_en,
    input  logic        suppress,
    input  logic        snooze_op,
    input  logic        dismiss_op,
    output logic [7:0]  led_alarm,
    output logic        ringing,
    output logic        snoozed,
    output logic [15:0] snooze_time
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    localparam logic [7:0] RING_LAST    = 8'(RING_SECONDS - 1);
    localparam logic [2:0] SNOOZE_LIMIT = 3'(MAX_SNOOZE);
    localparam logic [6:0] SNOOZE_ADD   = 7'(SNOOZE_MINUTES);

    // Two BCD digits to binary (0..99).
    function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens,
                                              input logic [3:0] ones);
        logic [6:0] t7;
        t7 = 7'(tens);
        return (t7 << 3) + (t7 << 1) + 7'(ones);
    endfunction

    // Binary 0..99 to two BCD digits by repeated subtraction of ten; the
    // loop is fixed-length so it unrolls into a short compare/subtract chain.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] value);
        logic [6:0] rem;
        logic [3:0] tens;
        rem  = value;
        tens = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    state_t      state, state_n;
    logic        match_q;
    logic [7:0]  ring_cnt, ring_cnt_n;
    logic [7:0]  pattern, pattern_n;
    logic [2:0]  snooze_cnt, snooze_cnt_n;
    logic [15:0] snooze_time_n;
    logic [7:0]  led_n;

    logic [15:0] now_bcd;
    logic [15:0] alarm_bcd;
    logic        match;
    logic        match_rise;
    logic        at_snooze_time;

    logic [6:0]  min_bin;
    logic [6:0]  hr_bin;
    logic [6:0]  min_sum;
    logic [6:0]  min_new;
    logic [6:0]  hr_new;
    logic [15:0] snooze_calc;

    assign now_bcd        = {hr_1, hr_0, min_1, min_0};
    assign alarm_bcd      = {al_hr_1, al_hr_0, al_min_1, al_min_0};
    assign match          = (now_bcd == alarm_bcd);
    assign match_rise     = match & ~match_q;
    assign at_snooze_time = (now_bcd == snooze_time);

    // Snooze target = current time + SNOOZE_MINUTES, done in binary and
    // converted back to BCD. The minute sum never exceeds 118, so a single
    // conditional subtract of 60 is enough; hour 24 wraps to midnight.
    always_comb begin
        min_bin = bcd_to_bin(min_1, min_0);
        hr_bin  = bcd_to_bin(hr_1, hr_0);
        min_sum = min_bin + SNOOZE_ADD;
        min_new = min_sum;
        hr_new  = hr_bin;
        if (min_sum >= 7'd60) begin
            min_new = min_sum - 7'd60;
            hr_new  = hr_bin + 7'd1;
        end
        if (hr_new >= 7'd24) begin
            hr_new = 7'd0;
        end
        snooze_calc = {bin_to_bcd(hr_new), bin_to_bcd(min_new)};
    end

    // Next-state and next-datapath logic. The RING exits are ordered so that
    // dismiss beats everything, then alarm switch off, then the ring timeout,
    // and only then a snooze request. An ignored snooze (limit reached) falls
    // through to normal ringing so the chase and the second count keep going.
    // In SNOOZE a dismiss or switch-off also takes precedence over re-ringing.
    always_comb begin
        state_n       = state;
        ring_cnt_n    = ring_cnt;
        pattern_n     = pattern;
        snooze_cnt_n  = snooze_cnt;
        snooze_time_n = snooze_time;

        case (state)
            IDLE: begin
                if (match_rise && alarm_en && !suppress) begin
                    state_n      = RING;
                    ring_cnt_n   = 8'd0;
                    pattern_n    = 8'h01;
                    snooze_cnt_n = 3'd0;
                end
            end

            RING: begin
                if (dismiss_op || !alarm_en) begin
                    state_n = IDLE;
                end else if (sec_tick && (ring_cnt == RING_LAST)) begin
                    state_n = IDLE;
                end else if (snooze_op && (snooze_cnt < SNOOZE_LIMIT)) begin
                    state_n       = SNOOZE;
                    snooze_time_n = snooze_calc;
                    snooze_cnt_n  = snooze_cnt + 3'd1;
                end else begin
                    if (sec_tick) begin
                        ring_cnt_n = ring_cnt + 8'd1;
                    end
                    if (anim_tick) begin
                        pattern_n = {pattern[6:0], pattern[7]};
                    end
                end
            end

            SNOOZE: begin
                if (dismiss_op || !alarm_en) begin
                    state_n = IDLE;
                end else if (at_snooze_time) begin
                    state_n    = RING;
                    ring_cnt_n = 8'd0;
                    pattern_n  = 8'h01;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // Every alarm event starts with a fresh snooze budget.
        if (state_n == IDLE) begin
            snooze_cnt_n = 3'd0;
        end

        // Outputs are computed from the next state so that they can be
        // registered without adding a cycle of latency.
        led_n = (state_n == RING) ? pattern_n : 8'h00;
    end

    // State and datapath registers. match_q resets high so that a match
    // already present when reset is released is not seen as a rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            match_q     <= 1'b1;
            ring_cnt    <= 8'd0;
            pattern     <= 8'h00;
            snooze_cnt  <= 3'd0;
            snooze_time <= 16'h0000;
            led_alarm   <= 8'h00;
            ringing     <= 1'b0;
            snoozed     <= 1'b0;
        end else begin
            state       <= state_n;
            match_q     <= match;
            ring_cnt    <= ring_cnt_n;
            pattern     <= pattern_n;
            snooze_cnt  <= snooze_cnt_n;
            snooze_time <= snooze_time_n;
            led_alarm   <= led_n;
            ringing     <= (state_n == RING);
            snoozed     <= (state_n == SNOOZE);
        end
    end

endmodule
